// File: rtl/rob_age_picker.sv
// rob_age_picker: registered age-ordered multi-grant picker for circular ROB/issue-queue buffers
module rob_age_picker #(
   parameter int WIDTH  = 5,
   parameter int DEPTH  = 1 << WIDTH,
   parameter int NGRANT = 2,
   parameter int CNTW   = $clog2(NGRANT + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [WIDTH-1:0]        head_i,
   input  logic                    dir_i,
   input  logic [DEPTH-1:0]        req_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [NGRANT-1:0]       grant_valid_o,
   output logic [NGRANT*WIDTH-1:0] grant_idx_o,
   output logic [DEPTH-1:0]        grant_vec_o,
   output logic [CNTW-1:0]         grant_cnt_o
);
   logic [NGRANT-1:0]       sel_valid;
   logic [NGRANT*WIDTH-1:0] sel_idx;
   logic [DEPTH-1:0]        sel_vec;
   logic [WIDTH-1:0]        p;
   int                      n;
   logic                    accept;
   assign in_ready_o = !out_valid_o || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   // walk entries in search order from the head; WIDTH-bit overflow provides the wrap
   always_comb begin
      sel_valid = '0;
      sel_idx   = '0;
      sel_vec   = '0;
      p         = '0;
      n         = 0;
      for (int o = 0; o < DEPTH; o++) begin
         p = dir_i ? head_i - WIDTH'(o + 1) : head_i + WIDTH'(o);
         if (req_i[p] && n < NGRANT) begin
            for (int k = 0; k < NGRANT; k++) begin
               if (k == n) begin
                  sel_valid[k]              = 1'b1;
                  sel_idx[k*WIDTH +: WIDTH] = p;
               end
            end
            sel_vec[p] = 1'b1;
            n          = n + 1;
         end
      end
   end
   // result register: flush drops the valid state, accept loads, consume without refill drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_o   <= 1'b0;
         grant_valid_o <= '0;
         grant_idx_o   <= '0;
         grant_vec_o   <= '0;
         grant_cnt_o   <= '0;
      end else if (flush_i) begin
         out_valid_o   <= 1'b0;
         grant_valid_o <= '0;
         grant_vec_o   <= '0;
         grant_cnt_o   <= '0;
      end else if (accept) begin
         out_valid_o   <= 1'b1;
         grant_valid_o <= sel_valid;
         grant_idx_o   <= sel_idx;
         grant_vec_o   <= sel_vec;
         grant_cnt_o   <= CNTW'(n);
      end else if (out_ready_i) begin
         out_valid_o   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rob_age_picker.sv
// tb_rob_age_picker: scenario tasks with a scoreboard of expected picker results
module tb_rob_age_picker;
   localparam int W  = 5;
   localparam int D  = 32;
   localparam int NG = 2;
   localparam int CW = $clog2(NG + 1);
   typedef struct packed {
      logic [NG-1:0]   gv;
      logic [NG*W-1:0] idx;
      logic [D-1:0]    vec;
      logic [CW-1:0]   cnt;
   } res_t;
   logic          clk = 0, rst_n = 0, flush_i = 0, in_valid_i = 0, dir_i = 0, out_ready_i = 0;
   logic [W-1:0]  head_i = '0;
   logic [D-1:0]  req_i = '0;
   logic          in_ready_o, out_valid_o;
   logic [NG-1:0]   grant_valid_o;
   logic [NG*W-1:0] grant_idx_o;
   logic [D-1:0]    grant_vec_o;
   logic [CW-1:0]   grant_cnt_o;
   res_t got, exp;
   res_t q[$];
   int n_cmp = 0, n_bad = 0;
   rob_age_picker #(.WIDTH(W), .DEPTH(D), .NGRANT(NG)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .head_i(head_i), .dir_i(dir_i), .req_i(req_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .grant_valid_o(grant_valid_o), .grant_idx_o(grant_idx_o), .grant_vec_o(grant_vec_o),
      .grant_cnt_o(grant_cnt_o)
   );
   always #5 clk = ~clk;
   assign got = {grant_valid_o, grant_idx_o, grant_vec_o, grant_cnt_o};
   function automatic res_t model(logic [D-1:0] req, logic [W-1:0] head, logic dir);
      res_t r = '0;
      int   c = 0;
      int   p;
      for (int o = 0; o < D; o++) begin
         p = dir ? (int'(head) + 2 * D - 1 - o) % D : (int'(head) + o) % D;
         if (req[p] && c < NG) begin
            r.gv  = r.gv | (NG'(1) << c);
            r.idx = r.idx | ((NG * W)'(p) << (c * W));
            r.vec = r.vec | (D'(1) << p);
            c++;
         end
      end
      r.cnt = CW'(c);
      return r;
   endfunction
   task automatic drive(input logic [D-1:0] req, input logic [W-1:0] head, input logic dir);
      in_valid_i = 1;
      req_i      = req;
      head_i     = head;
      dir_i      = dir;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      tick();
      tick();
      rst_n = 1;
      n_cmp++;
      if ({out_valid_o, in_ready_o, got} !== {1'b0, 1'b1, res_t'(0)}) begin
         n_bad++;
         $display("FAIL reset: got v=%b r=%b %h, want v=0 r=1 0", out_valid_o, in_ready_o, got);
      end
   endtask
   task automatic test_oldest();
      out_ready_i = 1;
      drive(32'hA000_0002, 5'd30, 1'b0);
      q.push_back({2'b11, 5'd1, 5'd31, 32'h8000_0002, 2'd2});
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL oldest_ready: got %b want 1", in_ready_o);
      end
      tick();
      in_valid_i = 0;
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL oldest_wrap: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
   endtask
   task automatic test_youngest();
      drive(32'hA000_0002, 5'd30, 1'b1);
      q.push_back({2'b11, 5'd1, 5'd29, 32'h2000_0002, 2'd2});
      tick();
      in_valid_i = 0;
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL youngest: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
   endtask
   task automatic test_empty_partial();
      drive('0, 5'd3, 1'b0);
      q.push_back(res_t'(0));
      tick();
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL empty: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
      drive(32'h0000_0020, 5'd7, 1'b0);
      q.push_back({2'b01, 5'd0, 5'd5, 32'h0000_0020, 2'd1});
      tick();
      in_valid_i = 0;
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL partial: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
      tick();
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL drain: got v=%b want 0", out_valid_o);
      end
   endtask
   task automatic test_backpressure();
      logic [D-1:0] rb;
      logic [W-1:0] hb;
      logic         db;
      drive($urandom, W'($urandom), 1'b0);
      q.push_back(model(req_i, head_i, dir_i));
      tick();
      out_ready_i = 0;
      rb = $urandom;
      hb = W'($urandom);
      db = 1'b1;
      drive(rb, hb, db);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({out_valid_o, in_ready_o, got} !== {1'b1, 1'b0, q[0]}) begin
            n_bad++;
            $display("FAIL stall%0d: got v=%b r=%b %h want v=1 r=0 %h", i, out_valid_o, in_ready_o, got, q[0]);
         end
      end
      out_ready_i = 1;
      #1;
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL stall_release_ready: got %b want 1", in_ready_o);
      end
      void'(q.pop_front());
      q.push_back(model(rb, hb, db));
      tick();
      in_valid_i = 0;
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL stall_next: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
      tick();
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_no_dup: got v=%b want 0", out_valid_o);
      end
   endtask
   task automatic test_flush();
      drive($urandom, W'($urandom), 1'b1);
      q.push_back(model(req_i, head_i, dir_i));
      tick();
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL pre_flush: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
      flush_i = 1;
      drive($urandom | 32'h1, W'($urandom), 1'b0);
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_ready: got %b want 1", in_ready_o);
      end
      tick();
      flush_i    = 0;
      in_valid_i = 0;
      n_cmp++;
      if ({out_valid_o, grant_valid_o, grant_vec_o, grant_cnt_o} !== '0) begin
         n_bad++;
         $display("FAIL flush: got v=%b gv=%b vec=%h cnt=%0d want all 0", out_valid_o, grant_valid_o, grant_vec_o, grant_cnt_o);
      end
      tick();
      n_cmp++;
      if (out_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_discard: got v=%b want 0", out_valid_o);
      end
   endtask
   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(i[0] ? D'(1) << $urandom_range(0, D - 1) : D'($urandom), W'($urandom), i[1]);
         q.push_back(model(req_i, head_i, dir_i));
         tick();
         exp = q.pop_front();
         n_cmp++;
         if ({out_valid_o, got} !== {1'b1, exp}) begin
            n_bad++;
            $display("FAIL b2b%0d: got v=%b %h want v=1 %h", i, out_valid_o, got, exp);
         end
      end
      in_valid_i = 0;
   endtask
   task automatic test_async_reset();
      drive($urandom, W'($urandom), 1'b0);
      q.push_back(model(req_i, head_i, dir_i));
      tick();
      in_valid_i = 0;
      out_ready_i = 0;
      #2;
      rst_n = 0;
      #1;
      q.delete();
      n_cmp++;
      if ({out_valid_o, in_ready_o, got} !== {1'b0, 1'b1, res_t'(0)}) begin
         n_bad++;
         $display("FAIL async_reset: got v=%b r=%b %h want v=0 r=1 0", out_valid_o, in_ready_o, got);
      end
      @(negedge clk);
      rst_n = 1;
      out_ready_i = 1;
      drive(32'h0000_0180, 5'd8, 1'b0);
      q.push_back({2'b11, 5'd7, 5'd8, 32'h0000_0180, 2'd2});
      tick();
      in_valid_i = 0;
      exp = q.pop_front();
      n_cmp++;
      if ({out_valid_o, got} !== {1'b1, exp}) begin
         n_bad++;
         $display("FAIL post_reset: got v=%b %h want v=1 %h", out_valid_o, got, exp);
      end
   endtask
   initial begin
      test_reset();
      test_oldest();
      test_youngest();
      test_empty_partial();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_async_reset();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
